cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- System-control coprocessor 0 for the pipelined MIPS core; sits in the M stage, directly downstream of the bus bridge.
- Consumes the bridge's 6-bit hardware-interrupt vector and the M-stage exception code.
- Holds SR/Cause/EPC/PRId, serves mfc0/mtc0, raises the pipeline-flush request and supplies the eret return address.

Parameters:
- PRID, 32'h2021_0007, read-only value returned for register 15.
- EXC_VECTOR, 32'h0000_4180, handler entry address driven on handler_pc.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- rd_addr  input  5  CP0 register number for mfc0 read.
- wr_addr  input  5  CP0 register number for mtc0 write.
- wr_data  input  32  mtc0 write data.
- wr_en  input  1  mtc0 write enable (M stage).
- m_pc  input  32  PC of the instruction in M.
- m_bd  input  1  M instruction sits in a branch delay slot.
- m_exccode  input  5  exception code carried into M; 0 = none.
- hwint  input  6  interrupt lines from the bridge; bit 0 = timer 1, bit 1 = timer 2, bit 2 = external.
- exl_clr  input  1  eret in M.
- rd_data  output  32  read data, combinational.
- req  output  1  take exception/interrupt this cycle (flush request).
- epc_out  output  32  eret target.
- handler_pc  output  32  constant EXC_VECTOR.

Behaviour:
- Register fields:
  - SR(12): IM=[15:10], EXL=[1], IE=[0]; other bits read 0.
  - Cause(13): BD=[31], IP=[15:10], ExcCode=[6:2]; other bits read 0.
  - EPC(14): 32 bits.
  - PRId(15): constant PRID.
  - Any other address reads 0; writes to it are ignored.
- Reset (sync): SR=0, Cause=0, EPC=0. req=0 follows combinationally.
- Request logic, all combinational, same cycle:
  - int_req = |(hwint & SR.IM) & SR.IE & ~SR.EXL.
  - exc_req = (m_exccode != 0) & ~SR.EXL.
  - req = int_req | exc_req.
- Priority: interrupt over exception. ExcCode captured = 0 when int_req, else m_exccode.
- On req, at the next edge:
  - EXL <= 1.
  - Cause.BD <= m_bd.
  - Cause.ExcCode <= captured code.
  - EPC <= m_bd ? (m_pc - 4) : m_pc, with bits [1:0] forced to 0.
- Cause.IP <= hwint every cycle, independent of EXL/IE/req.
- mtc0:
  - When wr_en & ~req, write the addressed register: SR IM/EXL/IE fields, EPC full word.
  - Cause is not software-writable.
  - When req=1, the write is suppressed.
- exl_clr:
  - When exl_clr & ~req, EXL <= 0 at the next edge.
  - req and exl_clr together: req wins (EXL stays 1, EPC updated).
- epc_out = (wr_en & wr_addr==14 & ~req) ? {wr_data[31:2],2'b00} : EPC. This bypass lets mtc0 EPC followed by eret resolve without a stall.
- rd_data returns pre-edge register contents; no read-after-write bypass inside the block.
- Width rules: m_pc - 4 wraps modulo 2^32. ExcCode is truncated to 5 bits.
- Latency: req is same-cycle; state updates are visible on the next cycle.

Decomposition:
- Shared package/header: CP0 register numbers (12–15), SR/Cause field bit positions, ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), EXC_VECTOR.
- One natural sub-module, cp0_irq_arb: combinational computation of int_req/exc_req/captured ExcCode.
- Register file and update logic stay in cp0_unit.

Test Plan:
- reset=1 one cycle; then read 12, 13, 14, 15 -> 0, 0, 0, PRID; req=0 with hwint=6'b111111.
- mtc0 SR=32'h0000_0401 (IM0, IE); then hwint=6'b000001, m_pc=32'h3010, m_bd=0:
  - -> req=1 same cycle.
  - next cycle: EPC=32'h3010, Cause=32'h0000_0400, SR.EXL=1.
  - req stays 0 while EXL=1.
- m_exccode=12 (Ov), m_bd=1, m_pc=32'h3024, SR.EXL=0, no hwint:
  - -> req=1.
  - Cause = 32'h8000_0030.
  - EPC = 32'h3020.
- Interrupt and exception together: hwint[0] enabled, m_exccode=4 -> ExcCode=0 (interrupt wins).
- mtc0 EPC=32'h3103 in the same cycle as exl_clr -> epc_out=32'h3100 that cycle; next cycle EXL=0, EPC=32'h3100.
- req and exl_clr and wr_en to SR together -> SR.EXL=1 after the edge; SR.IM/IE unchanged by the write.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and the handler entry address.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Bit positions, shared by SR.IM and Cause.IP
  localparam int IM_LO    = 10;
  localparam int IM_HI    = 15;
  localparam int SR_EXL   = 1;
  localparam int SR_IE    = 0;
  localparam int CAUSE_BD = 31;
  localparam int EXC_LO   = 2;
  localparam int EXC_HI   = 6;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] DEFAULT_PRID       = 32'h2021_0007;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/cp0_irq_arb.sv
// Combinational arbitration between pending interrupts and the M-stage
// exception; interrupts take priority.
module cp0_irq_arb
  import cp0_pkg::*;
(
  input  logic [5:0] hwint,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] m_exccode,
  output logic       int_req,
  output logic       exc_req,
  output logic       req,
  output logic [4:0] exc_code
);

  assign int_req  = (|(hwint & im)) & ie & ~exl;
  assign exc_req  = (m_exccode != 5'd0) & ~exl;
  assign req      = int_req | exc_req;
  assign exc_code = int_req ? 5'(EXC_INT) : m_exccode;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId storage, mfc0/mtc0 access, exception
// request generation and eret return address.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID       = DEFAULT_PRID,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        wr_en,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exccode,
  input  logic [5:0]  hwint,
  input  logic        exl_clr,
  output logic [31:0] rd_data,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] epc_capture;
  logic        epc_write;

  cp0_irq_arb u_arb (
    .hwint     (hwint),
    .im        (sr_im),
    .ie        (sr_ie),
    .exl       (sr_exl),
    .m_exccode (m_exccode),
    .int_req   (int_req),
    .exc_req   (exc_req),
    .req       (req),
    .exc_code  (exc_code)
  );

  // A delay-slot instruction restarts at its branch
  assign epc_capture = (m_bd ? (m_pc - 32'd4) : m_pc) & 32'hFFFF_FFFC;
  assign epc_write   = wr_en & (wr_addr == REG_EPC) & ~req;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= hwint;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= m_bd;
        cause_exc <= exc_code;
        epc       <= epc_capture;
      end else begin
        if (wr_en && wr_addr == REG_SR) begin
          sr_im  <= wr_data[IM_HI:IM_LO];
          sr_exl <= wr_data[SR_EXL];
          sr_ie  <= wr_data[SR_IE];
        end
        if (epc_write)
          epc <= {wr_data[31:2], 2'b00};
        if (exl_clr)
          sr_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      REG_SR: begin
        rd_data[IM_HI:IM_LO] = sr_im;
        rd_data[SR_EXL]      = sr_exl;
        rd_data[SR_IE]       = sr_ie;
      end
      REG_CAUSE: begin
        rd_data[CAUSE_BD]      = cause_bd;
        rd_data[IM_HI:IM_LO]   = cause_ip;
        rd_data[EXC_HI:EXC_LO] = cause_exc;
      end
      REG_EPC:  rd_data = epc;
      REG_PRID: rd_data = PRID;
      default:  rd_data = '0;
    endcase
  end

  // Forward a same-cycle mtc0 EPC so a following eret needs no stall
  assign epc_out    = epc_write ? {wr_data[31:2], 2'b00} : epc;
  assign handler_pc = EXC_VECTOR;

endmodule

// File: tb/tb_cp0_unit.sv
// Randomized and directed check of cp0_unit against a word-level model of
// the CP0 registers.
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  rd_addr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exccode;
  logic [5:0]  hwint;
  logic        exl_clr;
  logic [31:0] rd_data;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  localparam logic [31:0] PRID_VAL = 32'h2021_0007;
  localparam logic [31:0] VEC_VAL  = 32'h0000_4180;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl_sr, mdl_cause, mdl_epc;
  logic [31:0] obs_rd, obs_epc;
  logic        obs_req;

  cp0_unit dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .m_pc       (m_pc),
    .m_bd       (m_bd),
    .m_exccode  (m_exccode),
    .hwint      (hwint),
    .exl_clr    (exl_clr),
    .rd_data    (rd_data),
    .req        (req),
    .epc_out    (epc_out),
    .handler_pc (handler_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    case (a)
      5'd12:   return mdl_sr;
      5'd13:   return mdl_cause;
      5'd14:   return mdl_epc;
      5'd15:   return PRID_VAL;
      default: return 32'h0;
    endcase
  endfunction

  task automatic doReset();
    reset = 1'b1;
    wr_en = 1'b0; exl_clr = 1'b0; m_exccode = 5'd0; hwint = 6'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_sr = 0; mdl_cause = 0; mdl_epc = 0;
  endtask

  // One cycle: drive, check combinational outputs, clock, advance model
  task automatic applyStimulus(input logic [4:0] ra, input logic [4:0] wa, input logic [31:0] wd,
                               input logic we, input logic [31:0] pc, input logic bd,
                               input logic [4:0] ec, input logic [5:0] hw, input logic clr);
    logic        int_hit, exl, ie, exp_req;
    logic [31:0] exp_epc_out, n_sr, n_cause, n_epc, ret;
    rd_addr = ra; wr_addr = wa; wr_data = wd; wr_en = we;
    m_pc = pc; m_bd = bd; m_exccode = ec; hwint = hw; exl_clr = clr;
    #2;
    exl     = mdl_sr[1];
    ie      = mdl_sr[0];
    int_hit = ((hw & mdl_sr[15:10]) != 6'd0) && ie && !exl;
    exp_req = int_hit || (ec != 5'd0 && !exl);
    exp_epc_out = (we && wa == 5'd14 && !exp_req) ? (wd & 32'hFFFF_FFFC) : mdl_epc;
    obs_rd = rd_data; obs_req = req; obs_epc = epc_out;
    checkOutput("req", {31'b0, req}, {31'b0, exp_req});
    checkOutput("rd_data", rd_data, modelRead(ra));
    checkOutput("epc_out", epc_out, exp_epc_out);
    checkOutput("handler_pc", handler_pc, VEC_VAL);

    n_sr = mdl_sr; n_cause = mdl_cause; n_epc = mdl_epc;
    n_cause[15:10] = hw;
    if (exp_req) begin
      n_sr[1] = 1'b1;
      n_cause[31] = bd;
      n_cause[6:2] = int_hit ? 5'd0 : ec;
      ret = bd ? pc - 32'd4 : pc;
      n_epc = ret & 32'hFFFF_FFFC;
    end else begin
      if (we && wa == 5'd12) n_sr = wd & 32'h0000_FC03;
      if (we && wa == 5'd14) n_epc = wd & 32'hFFFF_FFFC;
      if (clr) n_sr[1] = 1'b0;
    end
    @(posedge clk);
    mdl_sr = n_sr; mdl_cause = n_cause; mdl_epc = n_epc;
    #1;
  endtask

  task automatic readReg(input logic [4:0] ra, input logic [5:0] hw);
    applyStimulus(ra, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, hw, 1'b0);
  endtask

  initial begin
    logic [4:0]  ec_tab [8];
    logic [4:0]  ra, wa, ec;
    logic [31:0] wd;
    logic        we, clr;
    ec_tab[0] = 5'd0; ec_tab[1] = 5'd0; ec_tab[2] = 5'd0; ec_tab[3] = 5'd4;
    ec_tab[4] = 5'd5; ec_tab[5] = 5'd10; ec_tab[6] = 5'd12; ec_tab[7] = 5'd0;
    rd_addr = 0; wr_addr = 0; wr_data = 0; m_pc = 0; m_bd = 0;
    doReset();

    readReg(5'd12, 6'd0);  checkOutput("reset_sr", obs_rd, 32'h0);
    readReg(5'd13, 6'd0);  checkOutput("reset_cause", obs_rd, 32'h0);
    readReg(5'd14, 6'd0);  checkOutput("reset_epc", obs_rd, 32'h0);
    readReg(5'd15, 6'h3F); checkOutput("reset_prid", obs_rd, PRID_VAL);
    checkOutput("reset_req", {31'b0, obs_req}, 32'h0);

    applyStimulus(5'd0, 5'd12, 32'h0000_0401, 1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    applyStimulus(5'd12, 5'd0, 32'h0, 1'b0, 32'h3010, 1'b0, 5'd0, 6'd1, 1'b0);
    checkOutput("int_req", {31'b0, obs_req}, 32'h1);
    readReg(5'd14, 6'd1); checkOutput("int_epc", obs_rd, 32'h3010);
    checkOutput("int_exl_blocks", {31'b0, obs_req}, 32'h0);
    readReg(5'd13, 6'd1); checkOutput("int_cause", obs_rd, 32'h0000_0400);
    readReg(5'd12, 6'd1); checkOutput("int_sr_exl", obs_rd, 32'h0000_0403);

    applyStimulus(5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    applyStimulus(5'd0, 5'd0, 32'h0, 1'b0, 32'h3024, 1'b1, 5'd12, 6'd0, 1'b0);
    checkOutput("ov_req", {31'b0, obs_req}, 32'h1);
    readReg(5'd13, 6'd0); checkOutput("ov_cause", obs_rd, 32'h8000_0030);
    readReg(5'd14, 6'd0); checkOutput("ov_epc", obs_rd, 32'h3020);

    applyStimulus(5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    applyStimulus(5'd0, 5'd0, 32'h0, 1'b0, 32'h3040, 1'b0, 5'd4, 6'd1, 1'b0);
    readReg(5'd13, 6'd0); checkOutput("prio_exccode", {27'b0, obs_rd[6:2]}, 32'h0);

    applyStimulus(5'd0, 5'd14, 32'h3103, 1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    checkOutput("epc_bypass", obs_epc, 32'h3100);
    readReg(5'd12, 6'd0); checkOutput("eret_exl", obs_rd, 32'h0000_0401);
    readReg(5'd14, 6'd0); checkOutput("eret_epc", obs_rd, 32'h3100);

    applyStimulus(5'd0, 5'd12, 32'h0, 1'b1, 32'h3200, 1'b0, 5'd0, 6'd1, 1'b1);
    readReg(5'd12, 6'd0); checkOutput("req_wins_sr", obs_rd, 32'h0000_0403);

    for (int i = 0; i < 600; i++) begin
      ra  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 2));
      we  = ($urandom_range(0, 2) == 0);
      wd  = $urandom;
      if (wa == 5'd12 && $urandom_range(0, 1) == 1) wd[1:0] = 2'b01;
      ec  = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ec_tab[$urandom_range(0, 7)];
      clr = ($urandom_range(0, 3) == 0);
      applyStimulus(ra, wa, wd, we, $urandom, 1'($urandom), ec, 6'($urandom), clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
